// File: rtl/rst_seq_gen_pkg.sv
// -----------------------------------------------------------------------------
// rst_seq_gen_pkg
//  Shared types and helpers for the multi-channel reset generator.
//  - seq_state_e : power-up sequencer states
//  - cnt_w()     : width of a counter that must be able to hold 0..max_val
// -----------------------------------------------------------------------------
package rst_seq_gen_pkg;

  typedef enum logic [1:0] {
    SEQ_HOLD = 2'd0,  // global reset released, counting the initial hold
    SEQ_REL  = 2'd1,  // releasing channels one by one, SEQ_GAP apart
    SEQ_RUN  = 2'd2   // all channels released; terminal until global reset
  } seq_state_e;

  // Bits needed for a counter holding values 0..max_val (never less than 1).
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rst_hold_ch.sv
// -----------------------------------------------------------------------------
// rst_hold_ch
//  One channel of run-time reset stretching. A sampled request sets the hold
//  flag immediately; once the request drops, the flag stays set for MIN_HOLD
//  edges counted from the first edge that samples the request low. A request
//  seen again while holding reloads the counter, so the full stretch restarts
//  from the next drop.
//
//  Ports
//   clk_i     in   reference clock, posedge
//   rst_i     in   synchronous active-high reset, clears hold and counter
//   req_i     in   level reset request for this channel
//   hold_d_o  out  next-state of the hold flag (reset not applied); the parent
//                  registers it into the channel output so the request shows
//                  up on rst_no with a single cycle of latency
// -----------------------------------------------------------------------------
module rst_hold_ch
  import rst_seq_gen_pkg::*;
#(
  parameter int MIN_HOLD = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_i,
  output logic hold_d_o
);

  localparam int              HW        = cnt_w(MIN_HOLD);
  localparam logic [HW-1:0]   HOLD_LAST = HW'(MIN_HOLD - 1);

  logic          hold_q, hold_d;
  logic [HW-1:0] cnt_q, cnt_d;

  // The counter is zero on the first low edge (F) and the flag drops on the
  // edge where it has reached MIN_HOLD-1, i.e. at F+MIN_HOLD-1. The counter
  // stops at HOLD_LAST, so it never wraps.
  always_comb begin
    hold_d = hold_q;
    cnt_d  = cnt_q;
    if (req_i) begin
      hold_d = 1'b1;
      cnt_d  = '0;
    end else if (hold_q) begin
      if (cnt_q == HOLD_LAST) begin
        hold_d = 1'b0;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      hold_q <= hold_d;
      cnt_q  <= cnt_d;
    end
  end

  assign hold_d_o = hold_d;

endmodule

// File: rtl/rst_seq_gen.sv
// -----------------------------------------------------------------------------
// rst_seq_gen
//  Multi-channel reset generator. After the global reset drops, the sequencer
//  waits MIN_HOLD edges and then releases the active-low channel resets in
//  order (ch0 first), SEQ_GAP edges apart. Each channel can also be forced
//  back into reset at run time through its request input; that reset is
//  stretched by a per-channel rst_hold_ch instance.
//
//  Ports
//   ref_clk_i   in   reference clock, all logic on posedge
//   glob_rst_i  in   synchronous active-high global reset, dominates all
//   arst_req_i  in   per-channel level reset request [NUM_CH]
//   rst_no      out  per-channel active-low reset, registered [NUM_CH]
//   seq_busy_o  out  high while the release sequence is in progress
//   seq_done_o  out  one-cycle pulse as the last channel is released
// -----------------------------------------------------------------------------
module rst_seq_gen
  import rst_seq_gen_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int MIN_HOLD = 16,
  parameter int SEQ_GAP  = 4
) (
  input  logic              ref_clk_i,
  input  logic              glob_rst_i,
  input  logic [NUM_CH-1:0] arst_req_i,
  output logic [NUM_CH-1:0] rst_no,
  output logic              seq_busy_o,
  output logic              seq_done_o
);

  localparam int HW = cnt_w(MIN_HOLD);
  localparam int GW = cnt_w(SEQ_GAP);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [HW-1:0] HOLD_LAST = HW'(MIN_HOLD - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(SEQ_GAP - 1);
  localparam logic [CW-1:0] CH_LAST   = CW'(NUM_CH - 1);
  localparam logic [CW-1:0] CH_FIRST  = CW'((NUM_CH > 1) ? 1 : 0);

  // ---------------------------------------------------------------------------
  // Per-channel request stretchers
  // ---------------------------------------------------------------------------
  logic [NUM_CH-1:0] hold_d;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    rst_hold_ch #(
      .MIN_HOLD (MIN_HOLD)
    ) u_hold (
      .clk_i    (ref_clk_i),
      .rst_i    (glob_rst_i),
      .req_i    (arst_req_i[k]),
      .hold_d_o (hold_d[k])
    );
  end

  // ---------------------------------------------------------------------------
  // Release sequencer
  // ---------------------------------------------------------------------------
  seq_state_e        state_q, state_d;
  logic [HW-1:0]     hcnt_q, hcnt_d;   // initial hold counter
  logic [GW-1:0]     gap_q, gap_d;     // stagger between releases
  logic [CW-1:0]     ch_q, ch_d;       // next channel to release
  logic [NUM_CH-1:0] rel_q, rel_d;     // channels released by the sequence
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [NUM_CH-1:0] rst_no_q;

  // Counters only advance below their last value, so none of them can wrap.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    gap_d   = gap_q;
    ch_d    = ch_q;
    rel_d   = rel_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      SEQ_HOLD: begin
        if (hcnt_q == HOLD_LAST) begin
          rel_d[0] = 1'b1;
          if (NUM_CH == 1) begin
            state_d = SEQ_RUN;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = SEQ_REL;
            gap_d   = '0;
            ch_d    = CH_FIRST;
          end
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end

      SEQ_REL: begin
        if (gap_q == GAP_LAST) begin
          rel_d[ch_q] = 1'b1;
          gap_d       = '0;
          if (ch_q == CH_LAST) begin
            state_d = SEQ_RUN;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            ch_d = ch_q + 1'b1;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      SEQ_RUN: begin
        // terminal until global reset
      end

      default: begin
        state_d = SEQ_HOLD;
      end
    endcase
  end

  // Outputs are registered from next-state values so a release or a new
  // request shows on the pins right after the edge that decides it, while
  // still giving no combinational path from any input to any output.
  always_ff @(posedge ref_clk_i) begin
    if (glob_rst_i) begin
      state_q  <= SEQ_HOLD;
      hcnt_q   <= '0;
      gap_q    <= '0;
      ch_q     <= '0;
      rel_q    <= '0;
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
      rst_no_q <= '0;
    end else begin
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      gap_q    <= gap_d;
      ch_q     <= ch_d;
      rel_q    <= rel_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rst_no_q <= rel_d & ~hold_d;
    end
  end

  assign rst_no     = rst_no_q;
  assign seq_busy_o = busy_q;
  assign seq_done_o = done_q;

endmodule

// File: tb/tb_rst_seq_gen.sv
module tb_rst_seq_gen;
  localparam int NUM_CH   = 4;
  localparam int MIN_HOLD = 16;
  localparam int SEQ_GAP  = 4;
  localparam int DONE_T   = MIN_HOLD - 1 + (NUM_CH - 1) * SEQ_GAP;  // 27

  logic              clk = 1'b0;
  logic              glob_rst;
  logic [NUM_CH-1:0] arst_req;
  logic [NUM_CH-1:0] rst_no;
  logic              busy, done;

  int tests = 0;
  int fails = 0;

  // reference model state: edge count, edge of E0, last edge sampling a request
  int                n  = 0;
  int                e0 = -1;
  int                lastreq [NUM_CH];
  int                lowcnt  [NUM_CH];
  logic [NUM_CH-1:0] m_rst;
  logic              m_busy, m_done;

  always #5 clk = ~clk;

  rst_seq_gen #(
    .NUM_CH   (NUM_CH),
    .MIN_HOLD (MIN_HOLD),
    .SEQ_GAP  (SEQ_GAP)
  ) dut (
    .ref_clk_i  (clk),
    .glob_rst_i (glob_rst),
    .arst_req_i (arst_req),
    .rst_no     (rst_no),
    .seq_busy_o (busy),
    .seq_done_o (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hand-derived release schedule: bit k rises after E0+15+4k.
  function automatic logic [3:0] sched(input int j);
    if (j >= 27)      return 4'b1111;
    else if (j >= 23) return 4'b0111;
    else if (j >= 19) return 4'b0011;
    else if (j >= 15) return 4'b0001;
    else              return 4'b0000;
  endfunction

  // One clock: drive inputs, take the edge, update the timestamp model,
  // then compare every output and check low-pulse widths.
  task automatic cyc(input logic r, input logic [NUM_CH-1:0] q);
    int t;
    glob_rst = r;
    arst_req = q;
    @(posedge clk);
    n++;
    if (r) begin
      e0 = -1;
      for (int k = 0; k < NUM_CH; k++) lastreq[k] = -1000;
      m_rst  = '0;
      m_busy = 1'b1;
      m_done = 1'b0;
    end else begin
      if (e0 < 0) e0 = n;
      t = n - e0;
      for (int k = 0; k < NUM_CH; k++) begin
        if (q[k]) lastreq[k] = n;
        m_rst[k] = (t >= MIN_HOLD - 1 + k * SEQ_GAP) && (n - lastreq[k] >= MIN_HOLD);
      end
      m_done = (t == DONE_T);
      m_busy = (t < DONE_T);
    end
    #1;
    chk("model rst_no", rst_no, m_rst);
    chk("model busy", busy, m_busy);
    chk("model done", done, m_done);
    for (int k = 0; k < NUM_CH; k++) begin
      if (rst_no[k] === 1'b0) lowcnt[k]++;
      else begin
        if (lowcnt[k] > 0) chk("low pulse >= MIN_HOLD", lowcnt[k] >= MIN_HOLD, 1);
        lowcnt[k] = 0;
      end
    end
  endtask

  task automatic seq_chk(input string tag);
    for (int j = 0; j <= DONE_T; j++) begin
      cyc(1'b0, '0);
      chk({tag, " rst_no"}, rst_no, sched(j));
      chk({tag, " done"}, done, (j == DONE_T));
      chk({tag, " busy"}, busy, (j < DONE_T));
    end
    repeat (3) cyc(1'b0, '0);
    chk({tag, " done after"}, done, 0);
    chk({tag, " rst_no after"}, rst_no, 4'b1111);
  endtask

  initial begin
    logic [NUM_CH-1:0] rq;
    for (int k = 0; k < NUM_CH; k++) begin
      lastreq[k] = -1000;
      lowcnt[k]  = 0;
    end
    glob_rst = 1'b1;
    arst_req = '0;
    #2;

    // 1: power-up sequence
    repeat (5) cyc(1'b1, '0);
    chk("reset rst_no", rst_no, 4'b0000);
    chk("reset busy", busy, 1);
    chk("reset done", done, 0);
    seq_chk("t1");

    // 2: request on ch2 for three samples in SEQ_RUN
    cyc(1'b0, 4'b0100);
    chk("t2 first", rst_no, 4'b1011);
    repeat (2) cyc(1'b0, 4'b0100);
    for (int j = 0; j < 16; j++) begin
      cyc(1'b0, '0);
      chk("t2 hold", rst_no, (j < 15) ? 4'b1011 : 4'b1111);
    end

    // 3: ch1 re-requested 10 cycles into its hold
    cyc(1'b0, 4'b0010);
    chk("t3 first", rst_no, 4'b1101);
    for (int j = 0; j < 10; j++) begin
      cyc(1'b0, '0);
      chk("t3 hold1", rst_no, 4'b1101);
    end
    cyc(1'b0, 4'b0010);
    chk("t3 rereq", rst_no, 4'b1101);
    for (int j = 0; j < 16; j++) begin
      cyc(1'b0, '0);
      chk("t3 hold2", rst_no, (j < 15) ? 4'b1101 : 4'b1111);
    end

    // 4: one-cycle global reset right after ch1 released
    cyc(1'b1, '0);
    chk("t4 rst_no", rst_no, 4'b0000);
    chk("t4 busy", busy, 1);
    chk("t4 done", done, 0);
    seq_chk("t4");

    // 5: ch0 requested from E0 through E0+40
    repeat (2) cyc(1'b1, '0);
    for (int j = 0; j <= 40; j++) begin
      cyc(1'b0, 4'b0001);
      chk("t5 rst_no", rst_no, sched(j) & 4'b1110);
      chk("t5 done", done, (j == DONE_T));
    end
    for (int j = 0; j < 16; j++) begin
      cyc(1'b0, '0);
      chk("t5 ch0", rst_no, (j < 15) ? 4'b1110 : 4'b1111);
    end

    // 6: all channels requested together
    repeat (2) cyc(1'b0, 4'b1111);
    chk("t6 all low", rst_no, 4'b0000);
    for (int j = 0; j < 16; j++) begin
      cyc(1'b0, '0);
      chk("t6 release", rst_no, (j < 15) ? 4'b0000 : 4'b1111);
    end

    // soak: random global reset and request bursts against the model
    rq = '0;
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < NUM_CH; k++)
        if ($urandom_range(0, 99) < 6) rq[k] = ~rq[k];
      cyc(($urandom_range(0, 199) < 2), rq);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
